// File: rtl/game_pkg.sv
// Shared game widths, state encoding and score ceiling used by the game-state
// bookkeeping and the 7-segment display driver.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int unsigned SCORE_W           = 10;
  localparam int unsigned LIVES_W           = 2;
  localparam int unsigned COMBO_W           = 4;
  localparam int unsigned SCORE_MAX_DEFAULT = 999;

  // Counter width able to hold GRACE_CYCLES-1; at least one bit.
  function automatic int unsigned grace_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/score_life_tracker_grace_timer.sv
// Miss-immunity down-counter: loadable, decrements while enabled and nonzero,
// with a registered flag that mirrors (count != 0).
module grace_timer
  import game_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES = 500000,
  localparam int unsigned CW = grace_w(GRACE_CYCLES)
) (
  input  logic          clk_1mhz,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          count_en,
  output logic          active
);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count_en && (count != '0)) begin
      count_next = count - 1'b1;
    end
  end

  // Flag derives from the next value so it always equals (count != 0).
  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b0;
    end else begin
      count  <= count_next;
      active <= (count_next != '0);
    end
  end

endmodule

// File: rtl/score_life_tracker.sv
// Game-state bookkeeping: saturating score with combo bonus, lives, miss
// grace window and the IDLE/PLAYING/GAME_OVER state for the display driver.
module score_life_tracker
  import game_pkg::*;
#(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned SCORE_MAX    = SCORE_MAX_DEFAULT,
  parameter int unsigned HIT_POINTS   = 1,
  parameter int unsigned COMBO_THRESH = 3,
  parameter int unsigned COMBO_BONUS  = 1,
  parameter int unsigned GRACE_CYCLES = 500000
) (
  input  logic               clk_1mhz,
  input  logic               rst,
  input  logic               start_pulse,
  input  logic               hit_pulse,
  input  logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [COMBO_W-1:0] combo,
  output logic               playing,
  output logic               game_over,
  output logic               life_lost,
  output logic               grace_active
);

  localparam int unsigned GW    = grace_w(GRACE_CYCLES);
  localparam int unsigned SUM_W = SCORE_W + 1;

  localparam logic [SUM_W-1:0]   SUM_MAX    = SUM_W'(SCORE_MAX);
  localparam logic [SUM_W-1:0]   PTS_BASE   = SUM_W'(HIT_POINTS);
  localparam logic [SUM_W-1:0]   PTS_COMBO  = SUM_W'(HIT_POINTS + COMBO_BONUS);
  localparam logic [COMBO_W:0]   THRESH     = (COMBO_W + 1)'(COMBO_THRESH);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [GW-1:0]      GRACE_LOAD = (GRACE_CYCLES == 0) ? '0 : GW'(GRACE_CYCLES - 1);

  state_t              state;
  logic                start_entry;
  logic                miss_eff;
  logic                grace_load;
  logic [GW-1:0]       grace_val;
  logic [SUM_W-1:0]    sum;
  logic [SCORE_W-1:0]  score_hit;

  always_comb begin
    start_entry = (state != PLAYING) && start_pulse;
    miss_eff    = (state == PLAYING) && miss_pulse && !grace_active && (lives != '0);
    sum         = {1'b0, score} + (({1'b0, combo} >= THRESH) ? PTS_COMBO : PTS_BASE);
    score_hit   = (sum > SUM_MAX) ? SUM_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
    // Entering PLAYING clears the timer through the load path with value 0.
    grace_load  = start_entry ||
                  (miss_eff && (lives != LIVES_W'(1)) && (GRACE_CYCLES != 0));
    grace_val   = start_entry ? '0 : GRACE_LOAD;
  end

  grace_timer #(
    .GRACE_CYCLES(GRACE_CYCLES)
  ) u_grace_timer (
    .clk_1mhz (clk_1mhz),
    .rst      (rst),
    .load     (grace_load),
    .load_val (grace_val),
    .count_en (1'b1),
    .active   (grace_active)
  );

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      score     <= '0;
      lives     <= LIVES_INIT;
      combo     <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      life_lost <= 1'b0;
    end else begin
      life_lost <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start_pulse) begin
            state     <= PLAYING;
            score     <= '0;
            lives     <= LIVES_INIT;
            combo     <= '0;
            playing   <= 1'b1;
            game_over <= 1'b0;
          end
        end
        PLAYING: begin
          if (hit_pulse) begin
            score <= score_hit;
            combo <= (combo == '1) ? combo : combo + 1'b1;
          end
          // A coincident miss overrides the hit's combo update.
          if (miss_eff) begin
            combo     <= '0;
            lives     <= lives - 1'b1;
            life_lost <= 1'b1;
            if (lives == LIVES_W'(1)) begin
              state     <= GAME_OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_life_tracker.sv
// Scoreboard bench for score_life_tracker: a behavioural game model pushes the
// expected outputs for each driven cycle; they are popped after the clock edge.
`timescale 1ns/1ps
module tb_score_life_tracker;

  localparam int GRACE = 100;

  logic       clk_1mhz = 1'b0;
  logic       rst;
  logic       start_pulse, hit_pulse, miss_pulse;
  logic [9:0] score;
  logic [1:0] lives;
  logic [3:0] combo;
  logic       playing, game_over, life_lost, grace_active;

  always #500 clk_1mhz = ~clk_1mhz;

  score_life_tracker #(
    .INIT_LIVES  (3),
    .SCORE_MAX   (999),
    .HIT_POINTS  (1),
    .COMBO_THRESH(3),
    .COMBO_BONUS (1),
    .GRACE_CYCLES(GRACE)
  ) dut (
    .clk_1mhz    (clk_1mhz),
    .rst         (rst),
    .start_pulse (start_pulse),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .score       (score),
    .lives       (lives),
    .combo       (combo),
    .playing     (playing),
    .game_over   (game_over),
    .life_lost   (life_lost),
    .grace_active(grace_active)
  );

  typedef struct {
    int score;
    int lives;
    int combo;
    int playing;
    int game_over;
    int life_lost;
    int grace;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: 0 idle, 1 playing, 2 game over.
  int m_state, m_score, m_lives, m_combo, m_grace, m_ll;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 3; m_combo = 0; m_grace = 0; m_ll = 0;
    sb.delete();
  endtask

  task automatic model_step(input bit s, input bit h, input bit m);
    int  g;
    int  pts;
    bit  em;
    exp_t e;
    g    = (m_grace > 0) ? m_grace - 1 : 0;
    m_ll = 0;
    if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_score = 0; m_lives = 3; m_combo = 0; g = 0;
      end
    end else begin
      em = m && (m_grace == 0);
      if (h) begin
        pts     = 1 + ((m_combo >= 3) ? 1 : 0);
        m_score = (m_score + pts > 999) ? 999 : m_score + pts;
        m_combo = (m_combo < 15) ? m_combo + 1 : 15;
      end
      if (em) begin
        m_lives = m_lives - 1;
        m_combo = 0;
        m_ll    = 1;
        if (m_lives == 0) begin
          m_state = 2;
          g       = 0;
        end else begin
          g = GRACE - 1;
        end
      end
    end
    m_grace = g;
    e = '{m_score, m_lives, m_combo, int'(m_state == 1), int'(m_state == 2),
          m_ll, int'(m_grace != 0)};
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("score", int'(score), e.score);
      check("lives", int'(lives), e.lives);
      check("combo", int'(combo), e.combo);
      check("playing", int'(playing), e.playing);
      check("game_over", int'(game_over), e.game_over);
      check("life_lost", int'(life_lost), e.life_lost);
      check("grace_active", int'(grace_active), e.grace);
    end
  endtask

  // Drives one cycle of stimulus starting at posedge+1, compares at next posedge+1.
  task automatic step(input bit s, input bit h, input bit m);
    start_pulse = s; hit_pulse = h; miss_pulse = m;
    model_step(s, h, m);
    @(posedge clk_1mhz); #1;
    start_pulse = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_lives"}, int'(lives), 3);
    check({tag, "_combo"}, int'(combo), 0);
    check({tag, "_playing"}, int'(playing), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_life_lost"}, int'(life_lost), 0);
    check({tag, "_grace"}, int'(grace_active), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk_1mhz);
    check_reset_outs("rst");
    rst = 1'b0;
    @(posedge clk_1mhz); #1;
  endtask

  int seq [5] = '{1, 2, 3, 5, 7};
  int gcnt;

  initial begin
    rst = 1'b1; start_pulse = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
    model_reset();
    #1200;
    check_reset_outs("por");
    do_reset();

    // Events before start are ignored.
    step(0, 1, 0); step(0, 0, 1); step(0, 1, 1);
    check("idle_score", int'(score), 0);
    check("idle_lives", int'(lives), 3);

    step(1, 0, 0);
    check("start_playing", int'(playing), 1);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      check("hit_seq", int'(score), seq[i]);
      check("combo_seq", int'(combo), i + 1);
      idle(9);
    end

    // Grace window: a miss at +50 is absorbed, at +150 it costs a life.
    step(0, 0, 1);
    check("miss_lives", int'(lives), 2);
    check("miss_pulse_hi", int'(life_lost), 1);
    gcnt = int'(grace_active);
    for (int k = 1; k <= 150; k++) begin
      step(0, 0, (k == 50) || (k == 150));
      if (k == 1) check("miss_pulse_lo", int'(life_lost), 0);
      if (k == 50) check("grace_miss_ignored", int'(lives), 2);
      if (k < 150) gcnt += int'(grace_active);
    end
    check("grace_len", gcnt, GRACE - 1);
    check("miss2_lives", int'(lives), 1);

    idle(GRACE + 2);
    step(0, 0, 1);
    check("final_game_over", int'(game_over), 1);
    check("final_grace", int'(grace_active), 0);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 0);
    check("frozen_score", int'(score), 7);

    // Start wins over a coincident hit.
    step(1, 1, 0);
    check("restart_score", int'(score), 0);
    check("restart_lives", int'(lives), 3);

    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 1);
    check("hm_score", int'(score), 7);
    check("hm_lives", int'(lives), 2);
    check("hm_combo", int'(combo), 0);

    for (int i = 0; i < 600 && m_score < 999; i++) step(0, 1, 0);
    check("cap_score", int'(score), 999);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("cap_hold", int'(score), 999);
    check("combo_sat", int'(combo), 15);

    // Build score 42 inside a grace window, then reset asynchronously.
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 40 && m_score < 42; i++) step(0, 1, 0);
    check("pre_rst_score", int'(score), 42);
    check("pre_rst_grace", int'(grace_active), 1);
    #300;
    rst = 1'b1;
    #1;
    check_reset_outs("async");
    model_reset();
    @(posedge clk_1mhz); #1;
    check_reset_outs("held");
    @(negedge clk_1mhz);
    rst = 1'b0;
    @(posedge clk_1mhz); #1;
    step(0, 1, 0);
    check("post_rst_idle", int'(playing), 0);
    step(1, 0, 0);
    check("post_rst_start", int'(playing), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
